// File: rtl/data_mem_requester_if.sv
// Pipeline request/response channel and data-RAM port of the memory-stage requester.
// master = the requester itself; slave = the pipeline plus RAM that surround it.
interface data_mem_requester_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_funct3;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_in;
    logic                  mem_write;
    logic                  mem_read;
    logic [2:0]            mem_funct3;
    logic [31:0]           mem_data_out;
    logic                  mem_fault;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  resp_ready,
        input  mem_data_out, mem_fault,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_data_in, mem_write, mem_read, mem_funct3
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        output resp_ready,
        output mem_data_out, mem_fault,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_data_in, mem_write, mem_read, mem_funct3
    );
endinterface

// File: rtl/data_mem_requester.sv
// Memory-stage requester: one load/store at a time, misaligned halfword/word
// accesses split into byte beats, load data assembled and extended.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// ACCESS | one RAM beat per cycle until the last beat or a fault
// RESP   | resp_valid=1, rdata/fault held until the consumer accepts
module data_mem_requester #(
    parameter int ADDR_WIDTH = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    data_mem_requester_if.master   bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]            state;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [31:0]           cap_wdata;
    logic [2:0]            cap_funct3;
    logic                  cap_split;
    logic [1:0]            beat_cnt;
    logic [1:0]            last_beat;
    logic [31:0]           asm_data;
    logic [31:0]           resp_rdata_r;
    logic                  resp_fault_r;

    logic                  accept;
    logic                  req_legal;
    logic                  req_aligned;
    logic [1:0]            req_last;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [7:0]            beat_wbyte;
    logic [31:0]           asm_next;
    logic                  last_now;

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{d[7]}}, d[7:0]};
            F3_BU:   r = {24'b0, d[7:0]};
            F3_H:    r = {{16{d[15]}}, d[15:0]};
            F3_HU:   r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        req_last    = 2'd0;
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = !bus.req_write;
            default:          req_legal = 1'b0;
        endcase
        case (bus.req_funct3[1:0])
            2'b01:   req_aligned = !bus.req_addr[0];
            2'b10:   req_aligned = (bus.req_addr[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase
        if (!req_aligned) begin
            req_last = (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
        end
    end

    assign beat_addr  = cap_addr + ADDR_WIDTH'(beat_cnt);
    assign beat_wbyte = cap_wdata[{beat_cnt, 3'b000} +: 8];
    assign last_now   = (beat_cnt == last_beat);

    // split loads drop each beat's byte into its own lane; aligned loads take the word
    always_comb begin
        asm_next = asm_data;
        if (!cap_split) begin
            asm_next = bus.mem_data_out;
        end else begin
            asm_next[{beat_cnt, 3'b000} +: 8] = bus.mem_data_out[7:0];
        end
    end

    always_comb begin
        bus.mem_address = '0;
        bus.mem_data_in = 32'b0;
        bus.mem_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_funct3  = 3'b000;
        if (state == ACCESS) begin
            bus.mem_address = beat_addr;
            bus.mem_write   = cap_write;
            bus.mem_read    = !cap_write;
            bus.mem_funct3  = cap_split ? F3_B : cap_funct3;
            if (cap_write) begin
                bus.mem_data_in = cap_split ? {24'b0, beat_wbyte} : cap_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= 32'b0;
            cap_funct3   <= 3'b000;
            cap_split    <= 1'b0;
            beat_cnt     <= 2'd0;
            last_beat    <= 2'd0;
            asm_data     <= 32'b0;
            resp_rdata_r <= 32'b0;
            resp_fault_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write  <= bus.req_write;
                        cap_addr   <= bus.req_addr;
                        cap_wdata  <= bus.req_wdata;
                        cap_funct3 <= bus.req_funct3;
                        cap_split  <= !req_aligned;
                        last_beat  <= req_last;
                        beat_cnt   <= 2'd0;
                        asm_data   <= 32'b0;
                        if (req_legal) begin
                            state <= ACCESS;
                        end else begin
                            state        <= RESP;
                            resp_fault_r <= 1'b1;
                            resp_rdata_r <= 32'b0;
                        end
                    end
                end
                ACCESS: begin
                    // a fault abandons the remaining beats; bytes already stored stay stored
                    if (bus.mem_fault) begin
                        state        <= RESP;
                        resp_fault_r <= 1'b1;
                        resp_rdata_r <= 32'b0;
                    end else begin
                        if (!cap_write) begin
                            asm_data <= asm_next;
                        end
                        if (last_now) begin
                            state        <= RESP;
                            resp_fault_r <= 1'b0;
                            resp_rdata_r <= cap_write ? 32'b0 : extend_load(cap_funct3, asm_next);
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_fault = resp_fault_r;
endmodule
